// File: rtl/modular_subtractor_pipe_if.sv
// Valid/ready stream bundle for the modular subtractor: operand side (a, b) and result side (c).
interface modular_subtractor_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] a;
  logic [29:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] c;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/modular_subtractor_pipe.sv
// Two-stage streaming (a - b) mod Q with optional exact halving, for the INTT butterfly difference leg.
// Stage 1 forms the reduced difference, stage 2 optionally multiplies it by 2^-1 mod Q.
module modular_subtractor_pipe #(
  parameter int MOD_INDEX = 0,
  parameter bit HALVE     = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  modular_subtractor_pipe_if.slave bus
);

  function automatic logic [29:0] q_sel(input int idx);
    case (idx)
      0:       return 30'd1063321601;
      1:       return 30'd1063452673;
      2:       return 30'd1064697857;
      3:       return 30'd1065484289;
      4:       return 30'd1065811969;
      5:       return 30'd1068236801;
      6:       return 30'd1068433409;
      7:       return 30'd1068564481;
      8:       return 30'd1069219841;
      9:       return 30'd1070727169;
      10:      return 30'd1071513601;
      11:      return 30'd1072496641;
      default: return 30'd1073479681;
    endcase
  endfunction

  localparam logic [29:0] Q = q_sel(MOD_INDEX);
  // Q is odd, so for odd d: (d + Q) / 2 == (d >> 1) + (Q + 1) / 2, which never exceeds 30 bits.
  localparam logic [29:0] Q_HALF_UP = (Q >> 1) + 30'd1;

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic [30:0] diff;
  logic [29:0] d_next;
  logic [29:0] d_q;
  logic [29:0] c_next;
  logic [29:0] c_q;

  always_comb begin
    s2_adv = !s2_valid || bus.out_ready;
    s1_adv = !s1_valid || s2_adv;
    diff   = {1'b0, bus.a} - {1'b0, bus.b};
    d_next = diff[30] ? (diff[29:0] + Q) : diff[29:0];
    if (HALVE)
      c_next = d_q[0] ? ((d_q >> 1) + Q_HALF_UP) : (d_q >> 1);
    else
      c_next = d_q;
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.c         = c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      d_q      <= '0;
      c_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid)
          d_q <= d_next;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          c_q <= c_next;
      end
    end
  end

endmodule

// File: tb/tb_modular_subtractor_pipe.sv
// Bench for modular_subtractor_pipe: directed vector table, backpressure, mid-stream reset and a random soak.
module tb_modular_subtractor_pipe;

  localparam int NI = 4;
  localparam int INST_IDX [NI] = '{0, 0, 12, 7};
  localparam bit INST_H   [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_valid = 1'b0;
  logic [29:0] t_a = '0;
  logic [29:0] t_b = '0;
  logic        t_ordy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modular_subtractor_pipe_if bus0 ();
  modular_subtractor_pipe_if bus1 ();
  modular_subtractor_pipe_if bus2 ();
  modular_subtractor_pipe_if bus3 ();

  assign bus0.in_valid = t_valid; assign bus0.a = t_a; assign bus0.b = t_b; assign bus0.out_ready = t_ordy;
  assign bus1.in_valid = t_valid; assign bus1.a = t_a; assign bus1.b = t_b; assign bus1.out_ready = t_ordy;
  assign bus2.in_valid = t_valid; assign bus2.a = t_a; assign bus2.b = t_b; assign bus2.out_ready = t_ordy;
  assign bus3.in_valid = t_valid; assign bus3.a = t_a; assign bus3.b = t_b; assign bus3.out_ready = t_ordy;

  modular_subtractor_pipe #(.MOD_INDEX(0),  .HALVE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  modular_subtractor_pipe #(.MOD_INDEX(0),  .HALVE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  modular_subtractor_pipe #(.MOD_INDEX(12), .HALVE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  modular_subtractor_pipe #(.MOD_INDEX(7),  .HALVE(1'b0)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  logic [29:0] cs [NI];
  logic        ovs [NI];
  assign cs[0] = bus0.c; assign cs[1] = bus1.c; assign cs[2] = bus2.c; assign cs[3] = bus3.c;
  assign ovs[0] = bus0.out_valid; assign ovs[1] = bus1.out_valid;
  assign ovs[2] = bus2.out_valid; assign ovs[3] = bus3.out_valid;

  function automatic longint unsigned tb_q(input int idx);
    case (idx)
      0:  return 64'd1063321601;
      1:  return 64'd1063452673;
      2:  return 64'd1064697857;
      3:  return 64'd1065484289;
      4:  return 64'd1065811969;
      5:  return 64'd1068236801;
      6:  return 64'd1068433409;
      7:  return 64'd1068564481;
      8:  return 64'd1069219841;
      9:  return 64'd1070727169;
      10: return 64'd1071513601;
      11: return 64'd1072496641;
      default: return 64'd1073479681;
    endcase
  endfunction

  function automatic longint unsigned ref_c(input longint unsigned av, input longint unsigned bv,
                                            input int idx, input bit h);
    longint unsigned q;
    longint unsigned d;
    q = tb_q(idx);
    d = (av + q - bv) % q;
    if (h) d = (d % 2 == 0) ? d / 2 : (d + q) / 2;
    return d;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] a;
    logic [29:0] b;
    bit          halve;
    logic [29:0] exp;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [29:0] b;
  } item_t;

  item_t       sb_q [$];
  logic        held = 1'b0;
  logic [29:0] held_c [NI];
  int          n_out = 0;

  // One cycle of streaming traffic: drive on the falling edge, sample, update the scoreboard.
  task automatic step(input logic v, input logic [29:0] av, input logic [29:0] bv, input logic ordy,
                      output logic acc, output logic ov);
    item_t it;
    longint unsigned e;
    longint unsigned q;
    @(negedge clk);
    t_valid = v; t_a = av; t_b = bv; t_ordy = ordy;
    #1;
    chk("in_ready", longint'(bus0.in_ready), longint'(!(sb_q.size() == 2 && !ordy)));
    if (held) begin
      chk("stall_valid", longint'(bus0.out_valid), 1);
      for (int i = 0; i < NI; i++) chk("stall_c", longint'(cs[i]), longint'(held_c[i]));
    end
    if (sb_q.size() == 0) chk("idle_valid", longint'(bus0.out_valid), 0);
    ov  = bus0.out_valid;
    acc = v && bus0.in_ready;
    if (bus0.out_valid && ordy && sb_q.size() != 0) begin
      it = sb_q.pop_front();
      n_out++;
      for (int i = 0; i < NI; i++) begin
        chk("lane_valid", longint'(ovs[i]), 1);
        e = ref_c(longint'(it.a), longint'(it.b), INST_IDX[i], INST_H[i]);
        chk("stream_c", longint'(cs[i]), longint'(e));
        if (INST_H[i]) begin
          q = tb_q(INST_IDX[i]);
          chk("halve_inv", longint'((2 * longint'(cs[i])) % q),
              longint'((longint'(it.a) + q - longint'(it.b)) % q));
        end
      end
    end
    if (acc) begin
      it.a = av; it.b = bv;
      sb_q.push_back(it);
    end
    held = bus0.out_valid && !ordy;
    for (int i = 0; i < NI; i++) held_c[i] = cs[i];
  endtask

  task automatic drain(input string name, input int expect_out);
    logic acc;
    logic ov;
    int   guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      step(1'b0, '0, '0, 1'b1, acc, ov);
      guard++;
    end
    chk({name, "_drained"}, longint'(sb_q.size()), 0);
    chk({name, "_count"}, longint'(n_out), longint'(expect_out));
  endtask

  localparam longint unsigned Q0 = 64'd1063321601;

  initial begin
    vec_t        vt [10];
    logic        acc;
    logic        ov;
    logic [29:0] ra;
    logic [29:0] rb;
    int          k;
    int          cyc;
    logic        rv;
    logic        ro;

    vt[0] = '{30'd5,          30'd7,          1'b0, 30'd1063321599};
    vt[1] = '{30'd10,         30'd4,          1'b0, 30'd6};
    vt[2] = '{30'd123456,     30'd123456,     1'b0, 30'd0};
    vt[3] = '{30'd0,          30'd1063321600, 1'b0, 30'd1};
    vt[4] = '{30'd1063321600, 30'd0,          1'b0, 30'd1063321600};
    vt[5] = '{30'd10,         30'd4,          1'b1, 30'd3};
    vt[6] = '{30'd6,          30'd3,          1'b1, 30'd531660802};
    vt[7] = '{30'd4,          30'd5,          1'b1, 30'd531660800};
    vt[8] = '{30'd5,          30'd7,          1'b1, 30'd1063321600};
    vt[9] = '{30'd1063321600, 30'd0,          1'b1, 30'd531660800};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", longint'(bus0.out_valid), 0);
    chk("rst_c", longint'(bus0.c), 0);
    chk("rst_in_ready", longint'(bus0.in_ready), 1);
    rst = 1'b0;

    // Directed table: single item through an idle pipe, check two-cycle latency and value
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      t_valid = 1'b1; t_a = vt[i].a; t_b = vt[i].b; t_ordy = 1'b1;
      #1;
      chk("vec_in_ready", longint'(bus0.in_ready), 1);
      @(negedge clk);
      t_valid = 1'b0;
      #1;
      chk("vec_lat1_valid", longint'(vt[i].halve ? bus1.out_valid : bus0.out_valid), 0);
      @(negedge clk); #1;
      chk("vec_lat2_valid", longint'(vt[i].halve ? bus1.out_valid : bus0.out_valid), 1);
      chk("vec_c", longint'(vt[i].halve ? bus1.c : bus0.c), longint'(vt[i].exp));
    end
    @(negedge clk);
    t_valid = 1'b0;

    // Backpressure: 8 items, out_ready low for 5 cycles mid-stream
    n_out = 0;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 60) begin
      ra = 30'($urandom_range(0, 32'(Q0 - 1)));
      rb = 30'($urandom_range(0, 32'(Q0 - 1)));
      step(1'b1, ra, rb, !(cyc >= 3 && cyc < 8), acc, ov);
      if (acc) k++;
      cyc++;
    end
    chk("bp_accepted", longint'(k), 8);
    drain("bp", 8);

    // Async reset with two items in flight
    step(1'b1, 30'd100, 30'd1, 1'b1, acc, ov);
    step(1'b1, 30'd200, 30'd2, 1'b1, acc, ov);
    @(posedge clk);
    #2;
    t_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", longint'(bus0.out_valid), 0);
    chk("mid_rst_c", longint'(bus0.c), 0);
    chk("mid_rst_c_h", longint'(bus1.c), 0);
    sb_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_out = 0;
    step(1'b1, 30'd7, 30'd9, 1'b1, acc, ov);
    chk("post_rst_acc", longint'(acc), 1);
    step(1'b0, '0, '0, 1'b1, acc, ov);
    chk("post_rst_lat1", longint'(ov), 0);
    step(1'b0, '0, '0, 1'b1, acc, ov);
    chk("post_rst_lat2", longint'(ov), 1);
    chk("post_rst_count", longint'(n_out), 1);

    // Random soak with random in_valid / out_ready across four parameterisations
    n_out = 0;
    k = 0;
    cyc = 0;
    while (k < 3000 && cyc < 20000) begin
      rv = ($urandom_range(0, 9) < 7);
      ro = ($urandom_range(0, 9) < 7);
      ra = 30'($urandom_range(0, 32'(Q0 - 1)));
      rb = (($urandom_range(0, 15) == 0)) ? ra : 30'($urandom_range(0, 32'(Q0 - 1)));
      step(rv, ra, rb, ro, acc, ov);
      if (acc) k++;
      cyc++;
    end
    chk("soak_accepted", longint'(k), 3000);
    drain("soak", k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
